// File: rtl/alu_multibyte_ctrl.sv
// Multi-byte initiator for the 8-bit combinational ALU: drives one byte per cycle, LSB first,
// chaining carry. Optional signed-overflow output enabled by ALU_MULTIBYTE_OVF_EN.
module alu_multibyte_ctrl #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned LEN_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  input  logic                  cin,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  res_cout,
  output logic                  res_zero,
`ifdef ALU_MULTIBYTE_OVF_EN
  output logic                  res_ovf,
`endif
  output logic [2:0]            alu_fun,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  input  logic [7:0]            alu_out,
  input  logic                  alu_zero,
  input  logic                  alu_cout
);

  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [LEN_W-1:0] NB_L = LEN_W'(NBYTES);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e                   state_q;
  logic [2:0]               op_q;
  logic [NBYTES-1:0][7:0]   a_q;
  logic [NBYTES-1:0][7:0]   b_q;
  logic [NBYTES-1:0][7:0]   result_q;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         last_q;
  logic                     carry_q;
  logic                     zacc_q;
  logic                     arith;
  logic [LEN_W-1:0]         last_full;

  assign arith  = ~op_q[2];
  assign result = result_q;

  // Out-of-range or zero length means full width.
  assign last_full = ((len == '0) || (len > NB_L)) ? (NB_L - LEN_W'(1)) : (len - LEN_W'(1));

  // ALU drive depends only on registered state.
  always_comb begin
    alu_fun = 3'b000;
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_cin = 1'b0;
    if (state_q == StExec) begin
      alu_a = a_q[idx_q];
      if (arith) begin
        alu_fun = 3'b001;
        alu_b   = op_q[1] ? ~b_q[idx_q] : b_q[idx_q];
        alu_cin = carry_q;
      end else begin
        alu_fun = op_q;
        alu_b   = b_q[idx_q];
      end
    end
  end

`ifdef ALU_MULTIBYTE_OVF_EN
  logic ovf_now;
  assign ovf_now = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_cout <= 1'b0;
      res_zero <= 1'b0;
`ifdef ALU_MULTIBYTE_OVF_EN
      res_ovf  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q     <= op;
            a_q      <= opa;
            b_q      <= opb;
            last_q   <= last_full[IDX_W-1:0];
            idx_q    <= '0;
            // Add starts at 0, subtract at 1 (two's complement), *-with-carry use cin.
            carry_q  <= ~op[2] & (op[0] ? cin : op[1]);
            zacc_q   <= 1'b1;
            result_q <= '0;
            busy     <= 1'b1;
            state_q  <= StExec;
          end
        end
        StExec: begin
          result_q[idx_q] <= alu_out;
          if (arith) carry_q <= alu_cout;
          zacc_q <= zacc_q & alu_zero;
          if (idx_q == last_q) begin
            state_q  <= StDone;
            done     <= 1'b1;
            res_cout <= arith & alu_cout;
            res_zero <= zacc_q & alu_zero;
`ifdef ALU_MULTIBYTE_OVF_EN
            res_ovf  <= arith & ovf_now;
`endif
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multibyte_ctrl.sv
// Self-checking bench for alu_multibyte_ctrl: directed plan vectors plus random requests
// against a word-level arithmetic reference model and an 8-bit ALU model.
module tb_alu_multibyte_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [2:0]   op, len;
  logic [W-1:0] opa, opb, result;
  logic         busy, done, res_cout, res_zero;
  logic [2:0]   alu_fun;
  logic [7:0]   alu_a, alu_b, alu_out;
  logic         alu_cin, alu_zero, alu_cout;
`ifdef ALU_MULTIBYTE_OVF_EN
  logic         res_ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_multibyte_ctrl #(.NBYTES(NB), .LEN_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb), .cin(cin),
    .len(len), .busy(busy), .done(done), .result(result), .res_cout(res_cout),
    .res_zero(res_zero),
`ifdef ALU_MULTIBYTE_OVF_EN
    .res_ovf(res_ovf),
`endif
    .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_cout(alu_cout)
  );

  // 8-bit ALU: 001 add-with-carry, 100 and, 101 or, 110 xor, 111 a&~b.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'h000;
    case (alu_fun)
      3'b001:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      3'b100:  alu_sum = {1'b0, alu_a & alu_b};
      3'b101:  alu_sum = {1'b0, alu_a | alu_b};
      3'b110:  alu_sum = {1'b0, alu_a ^ alu_b};
      3'b111:  alu_sum = {1'b0, alu_a & ~alu_b};
      default: alu_sum = {1'b0, alu_a};
    endcase
  end
  assign alu_out  = alu_sum[7:0];
  assign alu_cout = alu_sum[8];
  assign alu_zero = (alu_sum[7:0] == 8'h00);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level reference: whole-operand arithmetic over the effective width.
  task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input int l, output logic [W-1:0] r,
                           output logic rc, output logic rz, output logic rv);
    logic [63:0] mask, am, bm, s;
    logic        c0;
    mask = (64'd1 << (8 * l)) - 64'd1;
    am   = {32'h0, a} & mask;
    rc   = 1'b0;
    rv   = 1'b0;
    if (!o[2]) begin
      bm = {32'h0, (o[1] ? ~b : b)} & mask;
      c0 = o[0] ? c : o[1];
      s  = am + bm + {63'h0, c0};
      r  = s[W-1:0] & mask[W-1:0];
      rc = s[8*l];
      rv = (am[8*l-1] == bm[8*l-1]) && (s[8*l-1] != am[8*l-1]);
    end else begin
      case (o[1:0])
        2'b00:   r = a & b;
        2'b01:   r = a | b;
        2'b10:   r = a ^ b;
        default: r = a & ~b;
      endcase
      r = r & mask[W-1:0];
    end
    rz = (r == '0);
  endtask

  // One request; noise scrambles inputs and holds start high while busy.
  task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic c, input logic [2:0] l, input bit noise);
    int          el;
    logic [W-1:0] er;
    logic        erc, erz, erv, c0;
    logic [63:0] am, bm, lm;
    el = (l == 3'd0 || l > 3'(NB)) ? NB : int'(l);
    ref_model(o, a, b, c, el, er, erc, erz, erv);
    am = {32'h0, a};
    bm = {32'h0, ((!o[2] && o[1]) ? ~b : b)};
    c0 = o[0] ? c : o[1];
    op = o; opa = a; opb = b; cin = c; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = noise;
    for (int i = 0; i < el; i++) begin
      chk("busy_exec", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("alu_a", 32'(alu_a), 32'(am[8*i +: 8]));
      chk("alu_b", 32'(alu_b), 32'(bm[8*i +: 8]));
      if (!o[2]) begin
        lm = (64'd1 << (8 * i)) - 64'd1;
        chk("alu_fun", 32'(alu_fun), 32'd1);
        chk("alu_cin", 32'(alu_cin),
            32'(((am & lm) + (bm & lm) + {63'h0, c0}) >> (8 * i)));
      end else begin
        chk("alu_fun", 32'(alu_fun), 32'(o));
        chk("alu_cin", 32'(alu_cin), 32'd0);
      end
      if (noise) begin
        opa = $urandom; opb = $urandom; op = 3'($urandom); cin = 1'($urandom);
        len = 3'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("result", result, er);
    chk("res_cout", 32'(res_cout), 32'(erc));
    chk("res_zero", 32'(res_zero), 32'(erz));
`ifdef ALU_MULTIBYTE_OVF_EN
    chk("res_ovf", 32'(res_ovf), 32'(erv));
`endif
    chk("alu_fun_done", 32'(alu_fun), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("result_hold", result, er);
    chk("res_cout_hold", 32'(res_cout), 32'(erc));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0; len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_res_cout", 32'(res_cout), 32'd0);
    chk("rst_res_zero", 32'(res_zero), 32'd0);
    chk("rst_alu", {21'h0, alu_fun, alu_a}, 32'h0);
    chk("rst_alu_b", {23'h0, alu_cin, alu_b}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(3'b000, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 3'd4, 1'b0);
    run(3'b010, 32'h0000_0000, 32'h0000_0001, 1'b0, 3'd4, 1'b0);
    run(3'b010, 32'h0000_0005, 32'h0000_0005, 1'b0, 3'd4, 1'b0);
    run(3'b000, 32'h1234_FFFF, 32'h0000_0001, 1'b0, 3'd2, 1'b0);
    run(3'b000, 32'h1234_FFFF, 32'h0000_0001, 1'b0, 3'd0, 1'b0);
    run(3'b110, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b0, 3'd4, 1'b0);
    run(3'b111, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 3'd4, 1'b0);
    run(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 3'd4, 1'b0);
    run(3'b011, 32'h8000_0000, 32'h0000_0001, 1'b0, 3'd6, 1'b1);
    run(3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'd4, 1'b0);

    // Abort after two EXEC edges: reset values, no done pulse.
    op = 3'b000; opa = 32'h0101_0101; opb = 32'h0101_0101; cin = 1'b0; len = 3'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", result, 32'h0);
    chk("abort_res_cout", 32'(res_cout), 32'd0);
    chk("abort_res_zero", 32'(res_zero), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      ra = $urandom;
      run(3'($urandom_range(0, 7)), ra, ($urandom_range(0, 3) == 0) ? ra : W'($urandom),
          1'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_multibyte_ctrl.md
Name: alu_multibyte_ctrl

Overview:
- Initiator-side controller for the team's 8-bit combinational ALU (fun/a/b/cin in; out/zero/cout back).
- Accepts one multi-byte arithmetic or logic request and drives the ALU one byte per cycle, LSB first, chaining carry between bytes.
- Assembles the wide result, final carry and whole-word zero flag, then pulses done.
- Sits between the datapath control logic and one ALU instance.

Parameters:
- NBYTES, 4, maximum operand width in bytes (operands are 8*NBYTES bits).
- LEN_W, 3, width of the len port; must satisfy 2**LEN_W > NBYTES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; honoured only in IDLE.
- op  in  3  operation; same encoding as the ALU fun field.
- opa  in  8*NBYTES  operand A.
- opb  in  8*NBYTES  operand B.
- cin  in  1  external carry-in; used by op 001 and 011 only.
- len  in  LEN_W  number of bytes to process.
- busy  out  1  high in EXEC and DONE.
- done  out  1  one-cycle pulse; result fields valid.
- result  out  8*NBYTES  assembled result.
- res_cout  out  1  final carry; for subtract ops, 1 = no borrow.
- res_zero  out  1  1 when all processed bytes are zero.
- alu_fun  out  3  to ALU fun.
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_cin  out  1  to ALU cin.
- alu_out  in  8  from ALU out.
- alu_zero  in  1  from ALU zero.
- alu_cout  in  1  from ALU cout.

Behaviour:
- The interface has one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State is IDLE; busy=0, done=0.
  - result=0, res_cout=0, res_zero=0.
  - Byte index, carry register and latched request are cleared.
- ALU drive:
  - alu_* outputs are combinational from registered state only. There is no path from start or opa/opb to the ALU outputs.
  - In IDLE and DONE, the ALU drive is fun=000, a=0, b=0, cin=0.
- IDLE:
  - When start=1, latch op, opa, opb, cin and len.
  - Clear result, set the carry register from the initial carry rule, set the zero accumulator to 1 and idx to 0.
  - Next state is EXEC.
- Effective length:
  - len=0 or len>NBYTES is treated as NBYTES.
- EXEC: one byte per cycle. alu_a is byte idx of A.
  - Add (000, 001): alu_fun=001, alu_b = byte idx of B.
    - Initial carry is 0 for 000, cin for 001.
  - Subtract (010, 011): alu_fun=001, alu_b = inverted byte idx of B (A + ~B + carry).
    - Initial carry is 1 for 010, cin for 011.
  - Logic (100..111): alu_fun=op, alu_b = byte idx of B, alu_cin=0. alu_cout is ignored.
  - alu_cin = the carry register for arithmetic ops.
- At each EXEC clock edge:
  - Store alu_out into byte idx of result.
  - Carry register <= alu_cout (arithmetic ops only).
  - Zero accumulator <= accumulator AND alu_zero.
  - If idx = effective len - 1, go to DONE; otherwise idx increments.
- Result width: bytes at or above the effective len stay 0.
- DONE (one cycle):
  - done=1.
  - res_cout = carry register (arithmetic) or 0 (logic).
  - res_zero = zero accumulator.
  - Next state is IDLE.
- result, res_cout and res_zero hold until the next accepted start.
- Latency: start is accepted at edge k; EXEC occupies effective-len cycles; done is high in cycle k+len+1.
- start during EXEC or DONE is ignored. No queuing. A start in the cycle done is high is dropped.
- Inputs are latched on acceptance. Changes to opa, opb, op, cin or len during busy have no effect.
- rst mid-operation: next cycle is IDLE with the reset values, and done is never pulsed for the aborted request.

Optional Feature:
- Macro: ALU_MULTIBYTE_OVF_EN
- With the macro defined:
  - Extra output port res_ovf (out, 1), reset 0, updated in DONE.
  - For arithmetic ops: res_ovf = signed overflow of the top processed byte. That is: the sign of alu_a equals the sign of the effective alu_b (after inversion), and the sign of alu_out differs from both.
  - This value is captured in the final EXEC cycle.
  - For logic ops: res_ovf=0.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Add with carry ripple: op=000, len=4, A=32'h00FF_FFFF, B=32'h0000_0001.
  - Expect result=32'h0100_0000, res_cout=0, res_zero=0.
  - done high exactly 5 cycles after the start edge; ALU sees fun=001, cin 0,1,1,1.
- Subtract with and without borrow: op=010, len=4.
  - 0 - 1: expect result=32'hFFFF_FFFF, res_cout=0 (borrow), res_ovf=0.
  - Then 5 - 5: expect result=0, res_cout=1, res_zero=1.
- Short length: op=000, len=2, A=32'h1234_FFFF, B=32'h0000_0001.
  - Expect result=32'h0000_0000, res_cout=1, res_zero=1, done 3 cycles after start.
  - len=0 behaves as len=4.
- Logic ops: op=110, A=B=32'hA5A5_5A5A, expect result=0, res_zero=1, res_cout=0.
  - op=111 with A=32'hFFFF_FFFF, B=32'h0F0F_0F0F: expect result=32'hF0F0_F0F0.
- Carry-in chaining: op=001, cin=1, A=32'hFFFF_FFFF, B=0, expect result=0, res_cout=1, res_zero=1.
  - Overflow check: op=000, A=32'h7FFF_FFFF, B=1, expect res_ovf=1.
- Abort and ignore:
  - rst after 2 EXEC cycles: busy=0 next cycle, result=0, no done pulse.
  - start asserted while busy: no effect on idx, latched operands or the done timing of the active request.
